// File: rtl/smc_seq_ctrl.sv
// Serial MOSFET calculator front-end: one shared evaluator, insertion-sorted
// result array and a weighted three-entry sum per six-device frame.
module smc_seq_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [2:0] W,
    input  logic [2:0] V_GS,
    input  logic [2:0] V_DS,
    input  logic [1:0] mode,
    output logic       out_valid,
    output logic [9:0] out_n,
    output logic       busy
);
    localparam int unsigned N_DEV = 6;
    localparam int unsigned RES_W = 7;
    localparam int unsigned OUT_W = 10;
    localparam int unsigned NUM_W = 9;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_SUM,
        S_OUT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic               ins_vld_q, ins_vld_d;
    logic [RES_W-1:0]   ins_q, ins_d;
    logic [RES_W-1:0]   arr_q [N_DEV];
    logic [RES_W-1:0]   arr_d [N_DEV];
    logic [OUT_W-1:0]   sum_q, sum_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_n_q, out_n_d;
    logic               busy_q, busy_d;

    logic [2:0]         vov_c;
    logic [3:0]         tri_term_c;
    logic               triode_c;
    logic               is_id_c;
    logic [NUM_W-1:0]   num_c;
    logic [RES_W-1:0]   eval_c;
    logic [RES_W-1:0]   arr_ins_c [N_DEV];
    logic [N_DEV-1:0]   gt_c;
    logic [RES_W-1:0]   n0_c, n1_c, n2_c;
    logic [OUT_W-1:0]   sum_c;

    // Shared evaluator; the first beat of a frame uses the live mode input.
    always_comb begin
        vov_c      = (V_GS != 3'd0) ? V_GS - 3'd1 : 3'd0;
        triode_c   = vov_c > V_DS;
        tri_term_c = 4'({vov_c, 1'b0}) - 4'(V_DS);
        is_id_c    = (state_q == S_IDLE) ? mode[0] : mode_q[0];
        if (is_id_c) begin
            if (triode_c) num_c = NUM_W'(W) * NUM_W'(V_DS) * NUM_W'(tri_term_c);
            else          num_c = NUM_W'(W) * NUM_W'(vov_c) * NUM_W'(vov_c);
        end else begin
            if (triode_c) num_c = NUM_W'(2) * NUM_W'(W) * NUM_W'(V_DS);
            else          num_c = NUM_W'(2) * NUM_W'(W) * NUM_W'(vov_c);
        end
        eval_c = RES_W'(num_c / NUM_W'(3));
    end

    // One insertion step into the descending array.
    always_comb begin
        for (int i = 0; i < N_DEV; i++) begin
            gt_c[i] = ins_q > arr_q[i];
        end
        arr_ins_c[0] = gt_c[0] ? ins_q : arr_q[0];
        for (int i = 1; i < N_DEV; i++) begin
            if (!gt_c[i])        arr_ins_c[i] = arr_q[i];
            else if (gt_c[i-1])  arr_ins_c[i] = arr_q[i-1];
            else                 arr_ins_c[i] = ins_q;
        end
    end

    always_comb begin
        n0_c  = mode_q[1] ? arr_q[0] : arr_q[3];
        n1_c  = mode_q[1] ? arr_q[1] : arr_q[4];
        n2_c  = mode_q[1] ? arr_q[2] : arr_q[5];
        if (mode_q[0]) begin
            sum_c = OUT_W'(3) * OUT_W'(n0_c) + OUT_W'(4) * OUT_W'(n1_c)
                  + OUT_W'(5) * OUT_W'(n2_c);
        end else begin
            sum_c = OUT_W'(n0_c) + OUT_W'(n1_c) + OUT_W'(n2_c);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        ins_vld_d   = 1'b0;
        ins_d       = ins_q;
        arr_d       = ins_vld_q ? arr_ins_c : arr_q;
        sum_d       = sum_q;
        out_valid_d = 1'b0;
        out_n_d     = '0;
        busy_d      = out_valid_q ? 1'b0 : busy_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d   = S_LOAD;
                    cnt_d     = CNT_W'(1);
                    mode_d    = mode;
                    ins_vld_d = 1'b1;
                    ins_d     = eval_c;
                    arr_d     = '{default: '0};
                    busy_d    = 1'b1;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    ins_vld_d = 1'b1;
                    ins_d     = eval_c;
                    if (cnt_q == CNT_W'(N_DEV - 1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_SUM;
            S_SUM: begin
                sum_d   = sum_c;
                state_d = S_OUT;
            end
            S_OUT: begin
                out_valid_d = 1'b1;
                out_n_d     = sum_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mode_q      <= '0;
            ins_vld_q   <= 1'b0;
            ins_q       <= '0;
            arr_q       <= '{default: '0};
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            out_n_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            ins_vld_q   <= ins_vld_d;
            ins_q       <= ins_d;
            arr_q       <= arr_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            out_n_q     <= out_n_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_n     = out_n_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_smc_seq_ctrl.sv
// Bench for smc_seq_ctrl: directed and random frames checked every cycle
// against a frame-level model (evaluate, sort, pick three, weight).
module tb_smc_seq_ctrl;
    typedef int arr6_t[6];
    typedef struct {
        int due;
        int val;
        int lit;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] W = '0;
    logic [2:0] V_GS = '0;
    logic [2:0] V_DS = '0;
    logic [1:0] mode = '0;
    logic       out_valid;
    logic [9:0] out_n;
    logic       busy;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   next_ok = 0;
    bit   frame_open = 1'b0;
    bit   run_chk = 1'b0;
    exp_t q[$];

    smc_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .W(W), .V_GS(V_GS),
        .V_DS(V_DS), .mode(mode), .out_valid(out_valid), .out_n(out_n), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int dev_val(input int w, input int g, input int d, input bit id);
        int vov;
        vov = (g >= 1) ? g - 1 : 0;
        if (vov > d) return id ? (w * d * (2 * vov - d)) / 3 : (2 * w * d) / 3;
        return id ? (w * vov * vov) / 3 : (2 * w * vov) / 3;
    endfunction

    function automatic int frame_val(input arr6_t w, input arr6_t g, input arr6_t d,
                                     input logic [1:0] m);
        int v[6];
        int t;
        int b;
        for (int i = 0; i < 6; i++) v[i] = dev_val(w[i], g[i], d[i], m[0]);
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 5 - i; j++)
                if (v[j] < v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
        b = m[1] ? 0 : 3;
        if (m[0]) return 3 * v[b] + 4 * v[b+1] + 5 * v[b+2];
        return v[b] + v[b+1] + v[b+2];
    endfunction

    // Per-cycle comparison of all outputs against the model's schedule.
    always @(negedge clk) begin
        if (rst_n && run_chk) begin
            bit exp_ov;
            int exp_n;
            exp_ov = (q.size() > 0) && (q[0].due == cyc);
            exp_n  = exp_ov ? q[0].val : 0;
            chk("out_valid", int'(out_valid), int'(exp_ov));
            chk("out_n", int'(out_n), exp_n);
            chk("busy", int'(busy), int'(frame_open || q.size() > 0));
            if (exp_ov) begin
                if (q[0].lit >= 0) chk("out_n_literal", int'(out_n), q[0].lit);
                void'(q.pop_front());
            end
        end
    end

    task automatic cycle_drive(input bit v, input logic [2:0] w, input logic [2:0] g,
                               input logic [2:0] d, input logic [1:0] m);
        @(negedge clk);
        in_valid = v; W = w; V_GS = g; V_DS = d; mode = m;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input bit v);
        cycle_drive(v, 3'($urandom), 3'($urandom), 3'($urandom), 2'($urandom));
    endtask

    task automatic run_frame(input arr6_t w, input arr6_t g, input arr6_t d,
                             input logic [1:0] m, input int stall_at, input int stall_len,
                             input bit toggle, input int lit, input int nbeats,
                             input int extra);
        logic [1:0] mb;
        while (cyc + 1 < next_ok) idle_cycle(1'($urandom));
        repeat (extra) idle_cycle(1'b0);
        for (int i = 0; i < nbeats; i++) begin
            if (i == stall_at) repeat (stall_len) idle_cycle(1'b0);
            mb = (i == 0 || !toggle) ? m : 2'($urandom);
            cycle_drive(1'b1, 3'(w[i]), 3'(g[i]), 3'(d[i]), mb);
            if (i == 0) frame_open = 1'b1;
        end
        in_valid = 1'b0;
        if (nbeats == 6) begin
            q.push_back('{due: cyc + 3, val: frame_val(w, g, d, m), lit: lit});
            frame_open = 1'b0;
            next_ok = cyc + 4;
        end
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            idle_cycle(1'b0);
            budget++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    arr6_t w1 = '{1, 1, 1, 1, 1, 1};
    arr6_t z0 = '{0, 0, 0, 0, 0, 0};
    arr6_t s7 = '{7, 7, 7, 7, 7, 7};
    arr6_t w3 = '{3, 3, 3, 6, 3, 7};
    arr6_t g3 = '{2, 3, 4, 4, 7, 7};
    arr6_t d3 = '{1, 1, 3, 3, 7, 7};

    initial begin
        arr6_t rw, rg, rd;
        // Pin the model to hand-computed values.
        chk("model_id_tri", dev_val(3, 3, 1, 1'b1), 3);
        chk("model_id_sat", dev_val(7, 7, 7, 1'b1), 84);
        chk("model_gm_max", dev_val(7, 7, 7, 1'b0), 28);
        chk("model_s3_11", frame_val(w3, g3, d3, 2'b11), 486);
        chk("model_s3_01", frame_val(w3, g3, d3, 2'b01), 44);
        chk("model_s3_10", frame_val(w3, g3, d3, 2'b10), 52);
        chk("model_s3_00", frame_val(w3, g3, d3, 2'b00), 10);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        run_chk = 1'b1;
        repeat (2) idle_cycle(1'b0);

        run_frame(w1, w1, z0, 2'b11, -1, 0, 1'b0, 0, 6, 0);
        run_frame(s7, s7, s7, 2'b11, -1, 0, 1'b0, 1008, 6, 1);
        run_frame(w3, g3, d3, 2'b11, -1, 0, 1'b0, 486, 6, 1);
        run_frame(w3, g3, d3, 2'b01, -1, 0, 1'b0, 44, 6, 0);
        run_frame(w3, g3, d3, 2'b10, -1, 0, 1'b0, 52, 6, 2);
        run_frame(w3, g3, d3, 2'b00, -1, 0, 1'b1, 10, 6, 0);
        run_frame(w3, g3, d3, 2'b10, -1, 0, 1'b1, 52, 6, 0);
        run_frame(w3, g3, d3, 2'b11, 3, 2, 1'b0, 486, 6, 1);
        wait_drain();

        // Reset mid-frame: busy drops at once and no strobe follows.
        run_frame(s7, s7, s7, 2'b11, -1, 0, 1'b0, -1, 4, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        frame_open = 1'b0;
        q.delete();
        next_ok = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) idle_cycle(1'b0);
        run_frame(s7, s7, s7, 2'b11, -1, 0, 1'b0, 1008, 6, 0);
        run_frame(w3, g3, d3, 2'b11, -1, 0, 1'b0, 486, 6, 0);
        run_frame(w3, g3, d3, 2'b00, -1, 0, 1'b0, 10, 6, 0);

        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < 6; i++) begin
                rw[i] = int'($urandom_range(0, 7));
                rg[i] = int'($urandom_range(0, 7));
                rd[i] = int'($urandom_range(0, 7));
            end
            run_frame(rw, rg, rd, 2'($urandom),
                      ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, 5)),
                      int'($urandom_range(0, 3)), 1'($urandom), -1, 6,
                      int'($urandom_range(0, 2)));
        end
        wait_drain();
        repeat (3) idle_cycle(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
